// File: rtl/video_rgb_to_gray_bin.sv
// video_rgb_to_gray_bin
//   AXI4-Stream stage that turns {raw,R,G,B} pixels into a BT.601 luma value plus
//   a binarized bit (luma >= active threshold). tuser/tlast pass through unchanged.
//   Three-stage stallable pipeline with full backpressure, one pixel per cycle.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   param_threshold               requested threshold (quasi-static)
//   in_update_req                 permits the threshold to latch at the next frame start
//   s_axi4s_t{user,last,data,valid} / s_axi4s_tready   input stream, tdata = {raw,R,G,B}
//   m_axi4s_t{user,last,data,valid} / m_axi4s_tready   output stream, tdata = {bin,gray}
//   out_threshold                 currently active threshold
//   out_frame_count               frame starts accepted since reset (wraps)
module video_rgb_to_gray_bin #(
  parameter int TUSER_WIDTH     = 1,
  parameter int DATA_WIDTH      = 10,
  parameter int S_TDATA_WIDTH   = 4*DATA_WIDTH,
  parameter int M_TDATA_WIDTH   = DATA_WIDTH+1,
  parameter int INIT_THRESHOLD  = 1 << (DATA_WIDTH-1),
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      param_threshold,
  input  logic                       in_update_req,
  input  logic [TUSER_WIDTH-1:0]     s_axi4s_tuser,
  input  logic                       s_axi4s_tlast,
  input  logic [S_TDATA_WIDTH-1:0]   s_axi4s_tdata,
  input  logic                       s_axi4s_tvalid,
  output logic                       s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]     m_axi4s_tuser,
  output logic                       m_axi4s_tlast,
  output logic [M_TDATA_WIDTH-1:0]   m_axi4s_tdata,
  output logic                       m_axi4s_tvalid,
  input  logic                       m_axi4s_tready,
  output logic [DATA_WIDTH-1:0]      out_threshold,
  output logic [FRAME_CNT_WIDTH-1:0] out_frame_count
);

  localparam int PW = DATA_WIDTH + 8;

  // Control / bookkeeping
  logic                       cke;
  logic                       accept;
  logic                       frame_start;
  logic [DATA_WIDTH-1:0]      thr_q, thr_d;
  logic [FRAME_CNT_WIDTH-1:0] fc_q, fc_d;
  logic [DATA_WIDTH-1:0]      beat_thr;

  // Stage 1: products
  logic                   v1_q;
  logic [PW-1:0]          pr_q, pg_q, pb_q, pr_d, pg_d, pb_d;
  logic [TUSER_WIDTH-1:0] u1_q;
  logic                   l1_q;
  logic [DATA_WIDTH-1:0]  t1_q;

  // Stage 2: rounded sum
  logic                   v2_q;
  logic [PW-1:0]          sum_q, sum_d;
  logic [TUSER_WIDTH-1:0] u2_q;
  logic                   l2_q;
  logic [DATA_WIDTH-1:0]  t2_q;

  // Stage 3: output register
  logic                   v3_q;
  logic [DATA_WIDTH-1:0]  gray_q, gray_d;
  logic                   bin_q, bin_d;
  logic [TUSER_WIDTH-1:0] u3_q;
  logic                   l3_q;

  logic [PW-1:0] r_ext, g_ext, b_ext;
  logic          unused_bits;

  assign cke            = !v3_q | m_axi4s_tready;
  assign s_axi4s_tready = cke;
  assign accept         = s_axi4s_tvalid & cke;
  assign frame_start    = accept & s_axi4s_tuser[0];

  assign r_ext = PW'(s_axi4s_tdata[3*DATA_WIDTH-1:2*DATA_WIDTH]);
  assign g_ext = PW'(s_axi4s_tdata[2*DATA_WIDTH-1:DATA_WIDTH]);
  assign b_ext = PW'(s_axi4s_tdata[DATA_WIDTH-1:0]);

  // Raw component and the fractional bits of the sum are intentionally dropped.
  assign unused_bits = ^{s_axi4s_tdata[S_TDATA_WIDTH-1:3*DATA_WIDTH], sum_q[7:0]};

  always_comb begin
    thr_d    = thr_q;
    fc_d     = fc_q;
    if (frame_start) begin
      if (in_update_req) thr_d = param_threshold;
      fc_d = fc_q + FRAME_CNT_WIDTH'(1);
    end
    // A frame-start beat already uses the threshold it brings with it.
    beat_thr = thr_d;

    pr_d   = r_ext * PW'(77);
    pg_d   = g_ext * PW'(150);
    pb_d   = b_ext * PW'(29);
    // Weights sum to 256, so the rounded sum fits in PW bits.
    sum_d  = pr_q + pg_q + pb_q + PW'(128);
    gray_d = sum_q[PW-1:8];
    bin_d  = (gray_d >= t2_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      thr_q  <= DATA_WIDTH'(INIT_THRESHOLD);
      fc_q   <= '0;
      v1_q   <= 1'b0;
      pr_q   <= '0;
      pg_q   <= '0;
      pb_q   <= '0;
      u1_q   <= '0;
      l1_q   <= 1'b0;
      t1_q   <= '0;
      v2_q   <= 1'b0;
      sum_q  <= '0;
      u2_q   <= '0;
      l2_q   <= 1'b0;
      t2_q   <= '0;
      v3_q   <= 1'b0;
      gray_q <= '0;
      bin_q  <= 1'b0;
      u3_q   <= '0;
      l3_q   <= 1'b0;
    end else begin
      thr_q <= thr_d;
      fc_q  <= fc_d;
      if (cke) begin
        v1_q   <= s_axi4s_tvalid;
        pr_q   <= pr_d;
        pg_q   <= pg_d;
        pb_q   <= pb_d;
        u1_q   <= s_axi4s_tuser;
        l1_q   <= s_axi4s_tlast;
        t1_q   <= beat_thr;

        v2_q   <= v1_q;
        sum_q  <= sum_d;
        u2_q   <= u1_q;
        l2_q   <= l1_q;
        t2_q   <= t1_q;

        v3_q   <= v2_q;
        gray_q <= gray_d;
        bin_q  <= bin_d;
        u3_q   <= u2_q;
        l3_q   <= l2_q;
      end
    end
  end

  assign m_axi4s_tvalid  = v3_q;
  assign m_axi4s_tdata   = {bin_q, gray_q};
  assign m_axi4s_tuser   = u3_q;
  assign m_axi4s_tlast   = l3_q;
  assign out_threshold   = thr_q;
  assign out_frame_count = fc_q;

endmodule

// File: tb/tb_video_rgb_to_gray_bin.sv
module tb_video_rgb_to_gray_bin;

  localparam int DW  = 10;
  localparam int FCW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [DW-1:0]  param_threshold;
  logic           in_update_req;
  logic [0:0]     s_tuser;
  logic           s_tlast;
  logic [4*DW-1:0] s_tdata;
  logic           s_tvalid;
  logic           s_tready;
  logic [0:0]     m_tuser;
  logic           m_tlast;
  logic [DW:0]    m_tdata;
  logic           m_tvalid;
  logic           m_tready;
  logic [DW-1:0]  out_threshold;
  logic [FCW-1:0] out_frame_count;

  always #5 clk = ~clk;

  video_rgb_to_gray_bin #(.FRAME_CNT_WIDTH(FCW)) dut (
    .clk(clk), .reset(reset),
    .param_threshold(param_threshold), .in_update_req(in_update_req),
    .s_axi4s_tuser(s_tuser), .s_axi4s_tlast(s_tlast), .s_axi4s_tdata(s_tdata),
    .s_axi4s_tvalid(s_tvalid), .s_axi4s_tready(s_tready),
    .m_axi4s_tuser(m_tuser), .m_axi4s_tlast(m_tlast), .m_axi4s_tdata(m_tdata),
    .m_axi4s_tvalid(m_tvalid), .m_axi4s_tready(m_tready),
    .out_threshold(out_threshold), .out_frame_count(out_frame_count)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [12:0] sb[$];  // {tuser, tlast, bin, gray}
  int thr_m = 512;
  int fc_m  = 0;
  bit stall_mode = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int gray_m(input int r, input int g, input int b);
    return (77*r + 150*g + 29*b + 128) >> 8;
  endfunction

  // Output backpressure: 1,0,0 repeating when stalling, else always ready.
  initial begin
    int ph = 0;
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_mode) begin
        m_tready = (ph == 0);
        ph = (ph + 1) % 3;
      end else begin
        m_tready = 1'b1;
      end
    end
  end

  // Monitor: pop and compare on every output handshake.
  initial begin
    logic [12:0] e;
    forever begin
      @(negedge clk);
      if (!reset && m_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got gray %0d with empty scoreboard", m_tdata[DW-1:0]);
        end else begin
          e = sb.pop_front();
          chk("out_gray", int'(m_tdata[DW-1:0]), int'(e[DW-1:0]));
          chk("out_bin",  int'(m_tdata[DW]),     int'(e[DW]));
          chk("out_last", int'(m_tlast),         int'(e[11]));
          chk("out_user", int'(m_tuser[0]),      int'(e[12]));
        end
      end
    end
  end

  task automatic send(input int r, input int g, input int b, input bit u, input bit l);
    int w = 0;
    int gy;
    s_tdata  = {DW'(0), DW'(r), DW'(g), DW'(b)};
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      n_checks++;
      $display("FAIL input_timeout: s_axi4s_tready stuck at %0d, required 1", s_tready);
    end
    if (u && in_update_req) thr_m = int'(param_threshold);
    if (u) fc_m = (fc_m + 1) % (1 << FCW);
    gy = gray_m(r, g, b);
    sb.push_back({u, l, (gy >= thr_m), DW'(gy)});
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    if (u) begin
      chk("frame_count", int'(out_frame_count), fc_m);
      chk("threshold",   int'(out_threshold),   thr_m);
    end
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    param_threshold = 10'd512;
    in_update_req = 1'b0;
    s_tuser = '0; s_tlast = 1'b0; s_tdata = '0; s_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_s_tready", int'(s_tready), 1);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_m_tvalid",    int'(m_tvalid),        0);
    chk("reset_threshold",   int'(out_threshold),   512);
    chk("reset_frame_count", int'(out_frame_count), 0);
    chk("reset_tdata",       int'(m_tdata),         0);
    @(posedge clk); #1;

    // 1: white pixel at frame start, latency
    in_update_req = 1'b1;
    param_threshold = 10'd512;
    send(1023, 1023, 1023, 1'b1, 1'b0);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (m_tvalid) begin lat = i; break; end
    end
    chk("latency", lat, 3);
    drain();

    // 2: single-component pixels
    in_update_req = 1'b0;
    send(1023, 0, 0, 1'b0, 1'b0);
    send(0, 1023, 0, 1'b0, 1'b0);
    send(0, 0, 1023, 1'b0, 1'b0);
    drain();

    // 3: 8-pixel line under backpressure
    stall_mode = 1'b1;
    for (int i = 0; i < 8; i++)
      send(i*100, 1023 - i*90, i*37, 1'b0, (i == 7));
    drain();
    stall_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // 4: threshold only changes at a frame start
    param_threshold = 10'd100;
    in_update_req = 1'b1;
    send(1023, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("thr_midframe", int'(out_threshold), 512);
    @(posedge clk); #1;
    send(1023, 0, 0, 1'b1, 1'b0);
    send(1023, 0, 0, 1'b0, 1'b0);
    in_update_req = 1'b0;
    param_threshold = 10'd900;
    send(1023, 0, 0, 1'b1, 1'b0);
    drain();

    // 5: reset with beats in flight
    send(500, 500, 500, 1'b0, 1'b0);
    send(600, 600, 600, 1'b0, 1'b0);
    send(700, 700, 700, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_m_tvalid",    int'(m_tvalid),        0);
    chk("rst_threshold",   int'(out_threshold),   512);
    chk("rst_frame_count", int'(out_frame_count), 0);
    sb.delete();
    thr_m = 512;
    fc_m  = 0;
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_idle", int'(m_tvalid), 0);
    end
    @(posedge clk); #1;

    // 6: frame counter wrap (1,2,3,0,1)
    for (int i = 0; i < 5; i++)
      send(i*200, i*150, i*100, 1'b1, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

endmodule
